// File: rtl/const_fetch_sequencer_pkg.sv
// Shared types for the constant-register fetch sequencer: FSM states and
// immediate-length encodings.
package const_fetch_sequencer_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned LEN_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    typedef enum logic [LEN_W-1:0] {
        LEN_NONE = 2'd0,
        LEN_BYTE = 2'd1,
        LEN_WORD = 2'd2,
        LEN_RSVD = 2'd3
    } len_e;

    // Reserved length is fetched as a full word.
    function automatic len_e norm_len(input len_e len);
        return (len == LEN_RSVD) ? LEN_WORD : len;
    endfunction

endpackage

// File: rtl/const_fetch_sequencer_if.sv
// Decode/execute-facing handshake and strobe bundle of the constant fetch
// sequencer. master = pipeline side, slave = sequencer.
interface const_fetch_sequencer_if;
    import const_fetch_sequencer_pkg::*;

    logic instr_valid;
    len_e const_len;
    logic mem_ready;
    logic flush;
    logic drive_lo_req;
    logic drive_hi_req;
    logic consume;
    logic load_lo_n;
    logic load_hi_n;
    logic a_main_lo_n;
    logic a_main_hi_n;
    logic pc_inc;
    logic fetch_busy;
    logic const_valid;
    logic err;

    modport master (
        output instr_valid, const_len, mem_ready, flush, drive_lo_req, drive_hi_req, consume,
        input  load_lo_n, load_hi_n, a_main_lo_n, a_main_hi_n, pc_inc, fetch_busy, const_valid, err
    );

    modport slave (
        input  instr_valid, const_len, mem_ready, flush, drive_lo_req, drive_hi_req, consume,
        output load_lo_n, load_hi_n, a_main_lo_n, a_main_hi_n, pc_inc, fetch_busy, const_valid, err
    );

endinterface

// File: rtl/const_fetch_sequencer_arbiter.sv
// MainBus drive arbiter for the low/high constant registers: low wins,
// drive enables are one-cycle, one-hot and only granted for loaded bytes.
module const_fetch_sequencer_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_drive_lo_req,
    input  logic i_drive_hi_req,
    input  logic i_lo_loaded,
    input  logic i_hi_loaded,
    output logic o_a_main_lo_n,
    output logic o_a_main_hi_n,
    output logic o_err_c
);

    logic w_grant_lo;
    logic w_grant_hi;
    logic r_a_main_lo_n;
    logic r_a_main_hi_n;

    assign w_grant_lo = i_drive_lo_req && i_lo_loaded && !i_flush;
    assign w_grant_hi = i_drive_hi_req && !i_drive_lo_req && i_hi_loaded && !i_flush;

    // Conflict or request for a byte that is not held; the caller masks on flush.
    assign o_err_c = (i_drive_lo_req && i_drive_hi_req)
                   || (i_drive_lo_req && !i_lo_loaded)
                   || (i_drive_hi_req && !i_hi_loaded);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_main_lo_n <= 1'b1;
            r_a_main_hi_n <= 1'b1;
        end else begin
            r_a_main_lo_n <= !w_grant_lo;
            r_a_main_hi_n <= !w_grant_hi;
        end
    end

    assign o_a_main_lo_n = r_a_main_lo_n;
    assign o_a_main_hi_n = r_a_main_hi_n;

endmodule

// File: rtl/const_fetch_sequencer.sv
// Fetches 0-2 immediate bytes behind an opcode into the low/high constant
// registers, steps the PC per byte and hands bus arbitration to the arbiter.
module const_fetch_sequencer
    import const_fetch_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    const_fetch_sequencer_if.slave   bus
);

    state_e r_state;
    len_e   r_len;
    logic   r_load_lo_n;
    logic   r_load_hi_n;
    logic   r_pc_inc;
    logic   r_fetch_busy;
    logic   r_const_valid;
    logic   r_err;

    logic   w_fetching;
    logic   w_accept;
    logic   w_start;
    logic   w_len_err;
    logic   w_busy_err;
    logic   w_lo_loaded;
    logic   w_hi_loaded;
    logic   w_arb_err_c;
    logic   w_a_main_lo_n;
    logic   w_a_main_hi_n;

    assign w_fetching  = (r_state == ST_FETCH_LO) || (r_state == ST_FETCH_HI);
    assign w_accept    = bus.instr_valid && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.consume));
    assign w_start     = w_accept && (bus.const_len != LEN_NONE);
    assign w_len_err   = w_accept && (bus.const_len == LEN_RSVD);
    assign w_busy_err  = bus.instr_valid && w_fetching;
    assign w_lo_loaded = (r_state == ST_HOLD);
    assign w_hi_loaded = (r_state == ST_HOLD) && (r_len == LEN_WORD);

    const_fetch_sequencer_arbiter u_arbiter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_flush        (bus.flush),
        .i_drive_lo_req (bus.drive_lo_req),
        .i_drive_hi_req (bus.drive_hi_req),
        .i_lo_loaded    (w_lo_loaded),
        .i_hi_loaded    (w_hi_loaded),
        .o_a_main_lo_n  (w_a_main_lo_n),
        .o_a_main_hi_n  (w_a_main_hi_n),
        .o_err_c        (w_arb_err_c)
    );

    // Strobes default inactive every cycle so each is exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_len         <= LEN_NONE;
            r_load_lo_n   <= 1'b1;
            r_load_hi_n   <= 1'b1;
            r_pc_inc      <= 1'b0;
            r_fetch_busy  <= 1'b0;
            r_const_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_load_lo_n <= 1'b1;
            r_load_hi_n <= 1'b1;
            r_pc_inc    <= 1'b0;
            if (bus.flush) begin
                r_state       <= ST_IDLE;
                r_len         <= LEN_NONE;
                r_fetch_busy  <= 1'b0;
                r_const_valid <= 1'b0;
            end else begin
                r_err <= r_err | w_len_err | w_busy_err | w_arb_err_c;
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state      <= ST_FETCH_LO;
                            r_len        <= norm_len(bus.const_len);
                            r_fetch_busy <= 1'b1;
                        end
                    end
                    ST_FETCH_LO: begin
                        if (bus.mem_ready) begin
                            r_load_lo_n <= 1'b0;
                            r_pc_inc    <= 1'b1;
                            if (r_len == LEN_WORD) begin
                                r_state <= ST_FETCH_HI;
                            end else begin
                                r_state      <= ST_HOLD;
                                r_fetch_busy <= 1'b0;
                            end
                        end
                    end
                    ST_FETCH_HI: begin
                        if (bus.mem_ready) begin
                            r_load_hi_n  <= 1'b0;
                            r_pc_inc     <= 1'b1;
                            r_state      <= ST_HOLD;
                            r_fetch_busy <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (bus.consume) begin
                            r_const_valid <= 1'b0;
                            if (w_start) begin
                                r_state      <= ST_FETCH_LO;
                                r_len        <= norm_len(bus.const_len);
                                r_fetch_busy <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_len   <= LEN_NONE;
                            end
                        end else begin
                            r_const_valid <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.load_lo_n   = r_load_lo_n;
    assign bus.load_hi_n   = r_load_hi_n;
    assign bus.a_main_lo_n = w_a_main_lo_n;
    assign bus.a_main_hi_n = w_a_main_hi_n;
    assign bus.pc_inc      = r_pc_inc;
    assign bus.fetch_busy  = r_fetch_busy;
    assign bus.const_valid = r_const_valid;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_const_fetch_sequencer.sv
// Bench for const_fetch_sequencer: directed scenario tables plus a random run
// checked against a byte-counting transaction model.
module tb_const_fetch_sequencer;
    import const_fetch_sequencer_pkg::*;

    typedef struct packed {
        logic load_lo_n;
        logic load_hi_n;
        logic a_lo_n;
        logic a_hi_n;
        logic pc_inc;
        logic busy;
        logic cv;
        logic err;
    } obs_t;

    // Inputs sampled at one edge: instr_valid, len, mem_ready, flush, lo_req, hi_req, consume.
    typedef struct packed {
        logic       iv;
        logic [1:0] len;
        logic       mr;
        logic       fl;
        logic       lo;
        logic       hi;
        logic       cons;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem_data = 8'h00;
    int n_tests = 0;
    int n_fail = 0;

    const_fetch_sequencer_if bus_if ();

    const_fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    obs_t w_act;
    assign w_act = {bus_if.load_lo_n, bus_if.load_hi_n, bus_if.a_main_lo_n, bus_if.a_main_hi_n,
                    bus_if.pc_inc, bus_if.fetch_busy, bus_if.const_valid, bus_if.err};

    // Constant registers and MemData latch on the far side of the strobes.
    logic [7:0] r_mdr = 8'h00;
    logic [7:0] r_lo = 8'h00;
    logic [7:0] r_hi = 8'h00;
    logic [7:0] main_bus;
    always @(posedge clk) begin
        if (bus_if.mem_ready) r_mdr <= mem_data;
        if (!bus_if.load_lo_n) r_lo <= r_mdr;
        if (!bus_if.load_hi_n) r_hi <= r_mdr;
    end
    assign main_bus = !bus_if.a_main_lo_n ? r_lo : (!bus_if.a_main_hi_n ? r_hi : 8'h00);

    // Reference: a transaction needs `need` bytes, has `got`; done when got == need.
    int   m_need = 0;
    int   m_got = 0;
    bit   m_act = 1'b0;
    obs_t exp_v = 8'hF0;
    always @(posedge clk or negedge rst_n) begin : ref_model
        int need, got;
        bit act, fetching, holding, take;
        obs_t e;
        if (!rst_n) begin
            m_act <= 1'b0;
            m_need <= 0;
            m_got <= 0;
            exp_v <= 8'hF0;
        end else begin
            need = m_need; got = m_got; act = m_act; e = exp_v;
            fetching = act && (got < need);
            holding = act && (got == need);
            e.load_lo_n = 1'b1; e.load_hi_n = 1'b1; e.a_lo_n = 1'b1; e.a_hi_n = 1'b1; e.pc_inc = 1'b0;
            take = 1'b0;
            if (bus_if.flush) begin
                act = 1'b0; e.busy = 1'b0; e.cv = 1'b0;
            end else begin
                if (bus_if.drive_lo_req || bus_if.drive_hi_req) begin
                    if (holding && bus_if.drive_lo_req) e.a_lo_n = 1'b0;
                    else if (holding && bus_if.drive_hi_req && need == 2) e.a_hi_n = 1'b0;
                    if ((bus_if.drive_lo_req && bus_if.drive_hi_req) || !holding ||
                        (bus_if.drive_hi_req && need < 2)) e.err = 1'b1;
                end
                if (fetching) begin
                    if (bus_if.instr_valid) e.err = 1'b1;
                    if (bus_if.mem_ready) begin
                        if (got == 0) e.load_lo_n = 1'b0; else e.load_hi_n = 1'b0;
                        e.pc_inc = 1'b1;
                        got = got + 1;
                    end
                end else if (holding) begin
                    if (bus_if.consume) begin
                        act = 1'b0; e.cv = 1'b0; take = bus_if.instr_valid;
                    end else begin
                        e.cv = 1'b1;
                    end
                end else begin
                    take = bus_if.instr_valid;
                end
                if (take && bus_if.const_len != LEN_NONE) begin
                    act = 1'b1; got = 0;
                    need = (bus_if.const_len == LEN_RSVD) ? 2 : int'(bus_if.const_len);
                    if (bus_if.const_len == LEN_RSVD) e.err = 1'b1;
                end
                e.busy = act && (got < need);
            end
            m_need <= need; m_got <= got; m_act <= act; exp_v <= e;
        end
    end

    task automatic drive(input stim_t s, input logic [7:0] d);
        bus_if.instr_valid  = s.iv;
        bus_if.const_len    = len_e'(s.len);
        bus_if.mem_ready    = s.mr;
        bus_if.flush        = s.fl;
        bus_if.drive_lo_req = s.lo;
        bus_if.drive_hi_req = s.hi;
        bus_if.consume      = s.cons;
        mem_data            = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(8'h00, 8'h00);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t st[3];
        obs_t ex[3];
        do_reset();
        n_tests++;
        if (w_act !== 8'hF0) begin n_fail++; $display("FAIL reset_idle act=%h exp=%h", w_act, 8'hF0); end
        // word fetch, instr_valid again while busy to make err sticky, then park in FETCH_HI
        st = '{'{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF4, 8'h7D, 8'hF5};
        for (int i = 0; i < 3; i++) begin
            drive(st[i], 8'h00);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL reset_pre[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (w_act !== 8'hF0) begin n_fail++; $display("FAIL reset_async act=%h exp=%h", w_act, 8'hF0); end
        tick();
        rst_n = 1'b1;
        drive(8'h10, 8'h00);
        tick();
        n_tests++;
        if (w_act !== 8'hF0) begin n_fail++; $display("FAIL reset_release act=%h exp=%h", w_act, 8'hF0); end
    endtask

    task automatic test_word_fetch();
        stim_t st[7];
        obs_t ex[7];
        logic [7:0] dat[7];
        st = '{'{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex  = '{8'hF4, 8'h7C, 8'hB8, 8'hF2, 8'hD2, 8'hE2, 8'hF2};
        dat = '{8'h34, 8'h34, 8'h12, 8'h12, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i], dat[i]);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL word[%0d] act=%h exp=%h", i, w_act, ex[i]); end
            if (i == 4 || i == 5) begin
                n_tests++;
                if (main_bus !== ((i == 4) ? 8'h34 : 8'h12)) begin
                    n_fail++; $display("FAIL word_bus[%0d] act=%h exp=%h", i, main_bus, (i == 4) ? 8'h34 : 8'h12);
                end
            end
        end
    endtask

    task automatic test_byte_stall();
        stim_t st[8];
        obs_t ex[8];
        st = '{'{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'h78, 8'hF2, 8'hD3, 8'hF3};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(st[i], 8'h5A);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL stall[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
    endtask

    task automatic test_hi_without_byte();
        stim_t st[5];
        obs_t ex[5];
        st = '{'{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF4, 8'h78, 8'hF2, 8'hF3, 8'hF3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(st[i], 8'h77);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL hi_nobyte[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
    endtask

    task automatic test_flush();
        stim_t st[3];
        obs_t ex[3];
        st = '{'{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF4, 8'hF0, 8'hF0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(st[i], 8'h00);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL flush[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[6];
        obs_t ex[6];
        st = '{'{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF4, 8'h78, 8'hF2, 8'hF4, 8'h78, 8'hF2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(st[i], 8'h00);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL b2b[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
    endtask

    task automatic test_len_reserved();
        stim_t st[4];
        obs_t ex[4];
        st = '{'{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
               '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        ex = '{8'hF5, 8'h7D, 8'hB9, 8'hF3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i], 8'h00);
            tick();
            n_tests++;
            if (w_act !== ex[i]) begin n_fail++; $display("FAIL len3[%0d] act=%h exp=%h", i, w_act, ex[i]); end
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) do_reset();
            s.iv   = bus_if.fetch_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
            s.len  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s.mr   = ($urandom_range(0, 9) < 6);
            s.fl   = ($urandom_range(0, 24) == 0);
            s.lo   = ($urandom_range(0, 6) == 0);
            s.hi   = ($urandom_range(0, 6) == 0);
            s.cons = ($urandom_range(0, 4) == 0);
            drive(s, 8'($urandom));
            tick();
            n_tests++;
            if (w_act !== exp_v) begin n_fail++; $display("FAIL rand[%0d] act=%h exp=%h", c, w_act, exp_v); end
            if ((!w_act.a_lo_n && !w_act.a_hi_n) ||
                ((!w_act.a_lo_n || !w_act.a_hi_n) && (!w_act.load_lo_n || !w_act.load_hi_n))) begin
                n_tests++; n_fail++;
                $display("FAIL rand_excl[%0d] act=%h exp=no overlapping low enables", c, w_act);
            end
        end
    endtask

    initial begin
        drive(8'h00, 8'h00);
        test_reset();
        test_word_fetch();
        test_byte_stall();
        test_hi_without_byte();
        test_flush();
        test_back_to_back();
        test_len_reserved();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
